// File: rtl/sram_arb_pkg.sv
// Shared types and sizing helpers for the SRAM port arbiter.
package sram_arb_pkg;

    typedef enum logic {IDLE, GRANT} arb_state_e;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    function automatic int owner_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: searches upward from last+1, wrapping at N.
module rr_pick
    import sram_arb_pkg::*;
#(
    parameter int N  = 3,
    parameter int IW = owner_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  winner,
    output logic [IW-1:0] idx
);

    int k;

    // Walk from the farthest candidate to the nearest so the nearest hit overwrites.
    always_comb begin
        winner = '0;
        idx    = '0;
        k      = 0;
        for (int i = N; i >= 1; i--) begin
            k = (int'(last) + i) % N;
            if (req[k]) begin
                winner = N'(1) << k;
                idx    = IW'(k);
            end
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Lock-on-hold round-robin arbiter sharing one SRAM port; requester 0 is the boot loader.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NUM_REQ  = 3,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_HOLD = 64
) (
    input  logic                      clk_i,
    input  logic                      reset_ni,
    input  logic                      boot_done_i,
    input  logic [NUM_REQ-1:0]        req_i,
    output logic [NUM_REQ-1:0]        gnt_o,
    input  logic [NUM_REQ-1:0]        wr_en_i,
    input  logic [NUM_REQ-1:0]        rd_en_i,
    input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
    input  logic [NUM_REQ*DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0]         rdata_o,
    output logic [NUM_REQ-1:0]        rvalid_o,
    output logic                      sram_wr_en_o,
    output logic                      sram_rd_en_o,
    output logic [ADDR_W-1:0]         sram_addr_o,
    output logic [DATA_W-1:0]         sram_data_o,
    input  logic [DATA_W-1:0]         sram_rdata_i
);

    localparam int OWNER_W = owner_w(NUM_REQ);
    localparam int HOLD_W  = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    arb_state_e          state, state_nxt;
    logic [OWNER_W-1:0]  owner, owner_nxt;
    logic [OWNER_W-1:0]  last_owner, last_owner_nxt;
    logic [OWNER_W-1:0]  win_idx;
    logic [OWNER_W-1:0]  rd_owner_p1;
    logic [NUM_REQ-1:0]  elig, owner_oh, win_oh;
    logic [HOLD_W-1:0]   hold_cnt, hold_cnt_nxt;
    logic                granted, others_pend, release_now;
    logic                vld_p1;
    logic [ADDR_W-1:0]   addr_hold;
    logic [DATA_W-1:0]   data_hold;

    // During boot only the housekeeping loader may compete.
    assign elig        = boot_done_i ? req_i : (req_i & NUM_REQ'(1));
    assign owner_oh    = NUM_REQ'(1) << owner;
    assign granted     = (state == GRANT);
    assign gnt_o       = granted ? owner_oh : '0;
    assign others_pend = |(elig & ~owner_oh);

    rr_pick #(.N(NUM_REQ), .IW(OWNER_W)) u_pick (
        .req    (elig),
        .last   (last_owner),
        .winner (win_oh),
        .idx    (win_idx)
    );

    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        last_owner_nxt = last_owner;
        hold_cnt_nxt   = hold_cnt;
        release_now    = 1'b0;
        case (state)
            IDLE: begin
                if (|win_oh) begin
                    state_nxt    = GRANT;
                    owner_nxt    = win_idx;
                    hold_cnt_nxt = '0;
                end
            end
            GRANT: begin
                release_now = !req_i[owner] || !elig[owner] ||
                              (others_pend && (hold_cnt == HOLD_LAST));
                if (release_now) begin
                    state_nxt      = IDLE;
                    last_owner_nxt = owner;
                end else if (others_pend && (hold_cnt != HOLD_LAST)) begin
                    hold_cnt_nxt = hold_cnt + HOLD_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A simultaneous write and read from the owner performs only the write.
    assign sram_wr_en_o = granted & wr_en_i[owner];
    assign sram_rd_en_o = granted & rd_en_i[owner] & ~wr_en_i[owner];
    assign sram_addr_o  = granted ? addr_i[owner*ADDR_W +: ADDR_W]  : addr_hold;
    assign sram_data_o  = granted ? wdata_i[owner*DATA_W +: DATA_W] : data_hold;
    assign rdata_o      = sram_rdata_i;
    assign rvalid_o     = vld_p1 ? (NUM_REQ'(1) << rd_owner_p1) : '0;

    // p0 -> p1: read issue to read-data return (one-cycle SRAM latency)
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state       <= IDLE;
            owner       <= '0;
            last_owner  <= '0;
            hold_cnt    <= '0;
            vld_p1      <= 1'b0;
            rd_owner_p1 <= '0;
            addr_hold   <= '0;
            data_hold   <= '0;
        end else begin
            state       <= state_nxt;
            owner       <= owner_nxt;
            last_owner  <= last_owner_nxt;
            hold_cnt    <= hold_cnt_nxt;
            vld_p1      <= sram_rd_en_o;
            rd_owner_p1 <= owner;
            addr_hold   <= sram_addr_o;
            data_hold   <= sram_data_o;
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomized and directed bench for sram_port_arbiter against a behavioural model.
module tb_sram_port_arbiter;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MH = 8;

    logic            clk_i = 1'b0;
    logic            reset_ni;
    logic            boot_done_i;
    logic [N-1:0]    req_i, gnt_o, wr_en_i, rd_en_i, rvalid_o;
    logic [N*AW-1:0] addr_i;
    logic [N*DW-1:0] wdata_i;
    logic [DW-1:0]   rdata_o, sram_data_o, sram_rdata_i;
    logic [AW-1:0]   sram_addr_o;
    logic            sram_wr_en_o, sram_rd_en_o;

    int n_chk  = 0;
    int n_pass = 0;

    // Model state: owner -1 means nobody holds the port.
    int            m_owner, m_last, m_hold, m_rd_owner;
    bit            m_rd_pend;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;

    always #5 clk_i = ~clk_i;

    sram_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(MH)) dut (
        .clk_i        (clk_i),
        .reset_ni     (reset_ni),
        .boot_done_i  (boot_done_i),
        .req_i        (req_i),
        .gnt_o        (gnt_o),
        .wr_en_i      (wr_en_i),
        .rd_en_i      (rd_en_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .rdata_o      (rdata_o),
        .rvalid_o     (rvalid_o),
        .sram_wr_en_o (sram_wr_en_o),
        .sram_rd_en_o (sram_rd_en_o),
        .sram_addr_o  (sram_addr_o),
        .sram_data_o  (sram_data_o),
        .sram_rdata_i (sram_rdata_i)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want)
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, got, want, $time);
        else
            n_pass++;
    endtask

    function automatic logic [N-1:0] bit_of(input int i);
        return (i < 0) ? '0 : N'(1 << i);
    endfunction

    task automatic model_reset();
        m_owner = -1; m_last = 0; m_hold = 0;
        m_rd_pend = 0; m_rd_owner = 0; m_addr = '0; m_data = '0;
    endtask

    // Advance the model by one clock using the inputs applied during the cycle.
    task automatic model_step();
        logic [N-1:0] elig;
        bit           other, rd_now;
        int           o, c;
        logic [AW-1:0] a_now;
        logic [DW-1:0] d_now;
        elig   = boot_done_i ? req_i : (req_i & N'(1));
        o      = m_owner;
        rd_now = (o >= 0) && rd_en_i[o] && !wr_en_i[o];
        a_now  = (o >= 0) ? addr_i[o*AW +: AW]  : m_addr;
        d_now  = (o >= 0) ? wdata_i[o*DW +: DW] : m_data;
        m_rd_pend  = rd_now;
        m_rd_owner = o;
        m_addr     = a_now;
        m_data     = d_now;
        if (o < 0) begin
            for (int j = 1; j <= N; j++) begin
                c = (m_last + j) % N;
                if (elig[c]) begin
                    m_owner = c;
                    m_hold  = 0;
                    break;
                end
            end
        end else begin
            other = (elig & ~bit_of(o)) != 0;
            if (!req_i[o] || !elig[o] || (other && m_hold == MH - 1)) begin
                m_last  = o;
                m_owner = -1;
            end else if (other) begin
                m_hold = m_hold + 1;
            end
        end
    endtask

    // Called at posedge+1 with inputs set; checks at the falling edge, then clocks the model.
    task automatic tick();
        #4;
        chk("gnt", gnt_o, bit_of(m_owner));
        chk("sram_wr", sram_wr_en_o, (m_owner >= 0) && wr_en_i[m_owner]);
        chk("sram_rd", sram_rd_en_o, (m_owner >= 0) && rd_en_i[m_owner] && !wr_en_i[m_owner]);
        chk("sram_addr", sram_addr_o, (m_owner >= 0) ? addr_i[m_owner*AW +: AW] : m_addr);
        chk("sram_data", sram_data_o, (m_owner >= 0) ? wdata_i[m_owner*DW +: DW] : m_data);
        chk("rvalid", rvalid_o, m_rd_pend ? bit_of(m_rd_owner) : '0);
        chk("rdata", rdata_o, sram_rdata_i);
        @(posedge clk_i);
        model_step();
        #1;
    endtask

    task automatic clear_inputs();
        boot_done_i = 0; req_i = '0; wr_en_i = '0; rd_en_i = '0;
        addr_i = '0; wdata_i = '0; sram_rdata_i = '0;
    endtask

    // Asserts reset off-edge, checks outputs at once, releases at posedge+1.
    task automatic assert_reset();
        reset_ni = 0;
        model_reset();
        #1;
        chk("rst_gnt", gnt_o, '0);
        chk("rst_rvalid", rvalid_o, '0);
        chk("rst_wr", sram_wr_en_o, 1'b0);
        chk("rst_rd", sram_rd_en_o, 1'b0);
        chk("rst_addr", sram_addr_o, '0);
        chk("rst_data", sram_data_o, '0);
        repeat (2) @(posedge clk_i);
        #1;
        reset_ni = 1;
    endtask

    initial begin
        int cnt [N];
        int order [$];
        int exp_order [4];
        int n1, last1, first2;
        logic [N-1:0] prev_gnt;
        exp_order = '{1, 2, 0, 1};

        // Boot phase: only the loader is served, then cores after boot_done.
        clear_inputs();
        assert_reset();
        req_i = 3'b111;
        tick();
        chk("boot_gnt", gnt_o, 3'b001);
        repeat (11) tick();
        chk("boot_hold", gnt_o, 3'b001);
        boot_done_i = 1;
        for (int c = 0; c < 20 && gnt_o[2:1] == 2'b00; c++) tick();
        chk("boot_first_core", gnt_o, 3'b010);
        boot_done_i = 0;
        tick();
        chk("revoke_drop", gnt_o, 3'b000);
        tick();
        chk("revoke_loader", gnt_o, 3'b001);

        // Round-robin: each owner releases after 4 grant cycles and re-requests.
        clear_inputs();
        assert_reset();
        boot_done_i = 1; req_i = 3'b111; prev_gnt = '0;
        foreach (cnt[k]) cnt[k] = 0;
        for (int c = 0; c < 80 && order.size() < 4; c++) begin
            for (int k = 0; k < N; k++) begin
                if (gnt_o[k]) begin
                    cnt[k]++;
                    if (cnt[k] == 4) req_i[k] = 1'b0;
                    if (prev_gnt == '0) order.push_back(k);
                end else if (!req_i[k]) begin
                    req_i[k] = 1'b1;
                    cnt[k]   = 0;
                end
            end
            prev_gnt = gnt_o;
            tick();
        end
        chk("rr_count", order.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < order.size()) chk("rr_order", order[i], exp_order[i]);

        // Hold limit: requester 1 holds while 2 waits.
        clear_inputs();
        assert_reset();
        boot_done_i = 1; req_i = 3'b110;
        n1 = 0; last1 = -1; first2 = -1;
        for (int c = 0; c < 40; c++) begin
            if (first2 < 0 && gnt_o == 3'b010) begin n1++; last1 = c; end
            if (first2 < 0 && gnt_o == 3'b100) first2 = c;
            tick();
        end
        chk("hold_len", n1, MH);
        chk("hold_gap", first2 - last1, 2);

        // Read path, then a read in the owner's final grant cycle.
        clear_inputs();
        assert_reset();
        boot_done_i = 1; req_i = 3'b100;
        tick();
        rd_en_i = 3'b100; addr_i[2*AW +: AW] = 32'h40; sram_rdata_i = 32'hDEADBEEF;
        tick();
        rd_en_i = '0;
        chk("rd_rvalid", rvalid_o, 3'b100);
        chk("rd_rdata", rdata_o, 32'hDEADBEEF);
        tick();
        rd_en_i = 3'b100; req_i = '0;
        tick();
        rd_en_i = '0;
        chk("rd_drop_gnt", gnt_o, 3'b000);
        chk("rd_drop_rvalid", rvalid_o, 3'b100);
        tick();

        // Gating of non-owner strobes and write-over-read priority.
        clear_inputs();
        assert_reset();
        boot_done_i = 1; req_i = 3'b100;
        tick();
        wr_en_i = 3'b010; addr_i[1*AW +: AW] = 32'h10;
        #1;
        chk("gate_wr", sram_wr_en_o, 1'b0);
        tick();
        wr_en_i = 3'b100; rd_en_i = 3'b100;
        #1;
        chk("wr_rd_wr", sram_wr_en_o, 1'b1);
        chk("wr_rd_rd", sram_rd_en_o, 1'b0);
        tick();
        wr_en_i = '0; rd_en_i = '0;
        chk("wr_rd_rvalid", rvalid_o, 3'b000);
        tick();

        // Asynchronous reset with a read in flight.
        clear_inputs();
        assert_reset();
        boot_done_i = 1; req_i = 3'b010;
        tick();
        rd_en_i = 3'b010;
        tick();
        rd_en_i = '0;
        chk("inflight_rvalid", rvalid_o, 3'b010);
        assert_reset();
        tick();
        chk("post_rst_gnt", gnt_o, 3'b010);

        // Randomized traffic with occasional boot_done toggles.
        clear_inputs();
        assert_reset();
        boot_done_i = 1;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0)  req_i = N'($urandom);
            if ($urandom_range(0, 29) == 0) boot_done_i = ~boot_done_i;
            wr_en_i      = N'($urandom) & N'($urandom);
            rd_en_i      = N'($urandom);
            addr_i       = {$urandom, $urandom, $urandom};
            wdata_i      = {$urandom, $urandom, $urandom};
            sram_rdata_i = $urandom;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
